noc_credit_injector: RTL and testbench

- Client-side transmitter for the credit-flow-control NoC. It drives the transmitter end of a credit link: `credit_vc_target`, `credit_packet` out, `credit_vc_credit_gnt` in.
- Client packets are accepted into per-VC queues and injected toward the downstream router.
- Per-VC credit counters ensure a flit is never sent without downstream buffer space.
- It sits between a PE/client and a BFT leaf port, replacing a terminator wherever the port is used.

---
 rtl/common_pkg.sv | 21 ++
 rtl/noc_vc_fifo.sv | 45 ++++
 rtl/noc_credit_injector.sv | 116 +++++++++++
 tb/tb_noc_credit_injector.sv | 321 ++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/common_pkg.sv
// Shared NoC endpoint definitions: default widths, credit/queue sizing
// and the {addr, data} packet layout used by injector and ejector.
package common_pkg;

  localparam int DEFAULT_A_W        = 8;
  localparam int DEFAULT_D_W        = 32;
  localparam int DEFAULT_CREDITS    = 4;
  localparam int DEFAULT_FIFO_DEPTH = 2;

  // Endpoints built with other widths keep the same field order,
  // packed as {addr, data} with addr in the upper bits.
  typedef struct packed {
    logic [DEFAULT_A_W-1:0] addr;
    logic [DEFAULT_D_W-1:0] data;
  } pkt_t;

  function automatic int vc_idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/noc_vc_fifo.sv
// Single-VC synchronous queue with head-of-line peek.
// Pointers carry a wrap bit to tell full from empty.
module noc_vc_fifo #(
  parameter int W     = 8,
  parameter int DEPTH = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         push,
  input  logic         pop,
  input  logic [W-1:0] din,
  output logic         full,
  output logic         empty,
  output logic [W-1:0] head
);

  localparam int AW = $clog2(DEPTH);

  logic [AW:0]  wr_ptr;
  logic [AW:0]  rd_ptr;
  logic [W-1:0] mem [DEPTH];

  assign empty = (wr_ptr == rd_ptr);
  assign full  = (wr_ptr[AW] != rd_ptr[AW]) &&
                 (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  assign head  = mem[rd_ptr[AW-1:0]];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (push && !full)
        wr_ptr <= wr_ptr + 1'b1;
      if (pop && !empty)
        rd_ptr <= rd_ptr + 1'b1;
    end
  end

  always_ff @(posedge clk) begin
    if (push && !full)
      mem[wr_ptr[AW-1:0]] <= din;
  end

endmodule

// File: rtl/noc_credit_injector.sv
// Client-side credit-flow transmitter: per-VC queues, per-VC credit
// counters and a round-robin pick of one flit per cycle.
module noc_credit_injector
  import common_pkg::*;
#(
  parameter int VC_W       = 2,
  parameter int A_W        = DEFAULT_A_W,
  parameter int D_W        = DEFAULT_D_W,
  parameter int CREDITS    = DEFAULT_CREDITS,
  parameter int FIFO_DEPTH = DEFAULT_FIFO_DEPTH
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      client_valid,
  output logic                      client_ready,
  input  logic [vc_idx_w(VC_W)-1:0] client_vc,
  input  logic [A_W-1:0]            client_addr,
  input  logic [D_W-1:0]            client_data,
  output logic [VC_W-1:0]           credit_vc_target,
  output logic [A_W+D_W-1:0]        credit_packet,
  input  logic [VC_W-1:0]           credit_vc_credit_gnt,
  output logic                      credit_err
);

  localparam int VI_W = vc_idx_w(VC_W);
  localparam int CW   = $clog2(CREDITS + 1);
  localparam int P_W  = A_W + D_W;

  logic [VC_W-1:0] full;
  logic [VC_W-1:0] empty;
  logic [VC_W-1:0] push;
  logic [VC_W-1:0] pop;
  logic [VC_W-1:0] elig;
  logic [VC_W-1:0] ovf;
  logic [P_W-1:0]  head [VC_W];
  logic [CW-1:0]   cred [VC_W];
  logic [CW:0]     sum  [VC_W];
  logic [P_W-1:0]  din;
  logic [VI_W-1:0] ptr;
  logic [VI_W-1:0] win;
  logic            send;

  assign din          = {client_addr, client_data};
  assign client_ready = ~full[client_vc];

  for (genvar g = 0; g < VC_W; g++) begin : g_vc
    assign push[g] = client_valid && client_ready &&
                     (client_vc == VI_W'(g));
    assign pop[g]  = send && (win == VI_W'(g));
    assign elig[g] = ~empty[g] && (cred[g] != '0);

    noc_vc_fifo #(
      .W     (P_W),
      .DEPTH (FIFO_DEPTH)
    ) u_fifo (
      .clk   (clk),
      .rst_n (rst_n),
      .push  (push[g]),
      .pop   (pop[g]),
      .din   (din),
      .full  (full[g]),
      .empty (empty[g]),
      .head  (head[g])
    );

    // Send and return net out before the saturation check.
    assign sum[g] = {1'b0, cred[g]}
                  + (CW+1)'(credit_vc_credit_gnt[g])
                  - (CW+1)'(pop[g]);
    assign ovf[g] = (sum[g] > (CW+1)'(CREDITS));

    always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n)
        cred[g] <= CW'(CREDITS);
      else if (ovf[g])
        cred[g] <= CW'(CREDITS);
      else
        cred[g] <= sum[g][CW-1:0];
    end
  end

  // Walk downward so the eligible VC nearest the pointer wins.
  always_comb begin
    send = 1'b0;
    win  = '0;
    for (int i = VC_W - 1; i >= 0; i--) begin
      if (elig[(int'(ptr) + i) % VC_W]) begin
        send = 1'b1;
        win  = VI_W'((int'(ptr) + i) % VC_W);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      credit_vc_target <= '0;
      credit_packet    <= '0;
      ptr              <= '0;
    end else begin
      credit_vc_target <= '0;
      if (send) begin
        credit_vc_target <= VC_W'(1) << win;
        credit_packet    <= head[win];
        ptr <= (int'(win) + 1 == VC_W) ? '0 : win + 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      credit_err <= 1'b0;
    else if (|ovf)
      credit_err <= 1'b1;
  end

endmodule

// File: tb/tb_noc_credit_injector.sv
// Self-checking bench: queue/credit reference model driven cycle by cycle
// with directed scenarios followed by random traffic.
module tb_noc_credit_injector;

  localparam int VC_W    = 2;
  localparam int A_W     = 8;
  localparam int D_W     = 8;
  localparam int CREDITS = 2;
  localparam int DEPTH   = 2;

  logic             clk = 1'b0;
  logic             rst_n = 1'b0;
  logic             client_valid = 1'b0;
  logic             client_ready;
  logic [0:0]       client_vc = '0;
  logic [A_W-1:0]   client_addr = '0;
  logic [D_W-1:0]   client_data = '0;
  logic [VC_W-1:0]  credit_vc_target;
  logic [15:0]      credit_packet;
  logic [VC_W-1:0]  gnt = '0;
  logic             credit_err;

  int vectors = 0;
  int miscompares = 0;

  typedef logic [15:0] pq_t [$];
  pq_t mq [2];
  int  mcred [2];
  int  mptr;
  bit  merr;

  noc_credit_injector #(
    .VC_W       (VC_W),
    .A_W        (A_W),
    .D_W        (D_W),
    .CREDITS    (CREDITS),
    .FIFO_DEPTH (DEPTH)
  ) dut (
    .clk                  (clk),
    .rst_n                (rst_n),
    .client_valid         (client_valid),
    .client_ready         (client_ready),
    .client_vc            (client_vc),
    .client_addr          (client_addr),
    .client_data          (client_data),
    .credit_vc_target     (credit_vc_target),
    .credit_packet        (credit_packet),
    .credit_vc_credit_gnt (gnt),
    .credit_err           (credit_err)
  );

  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic model_reset();
    mq[0].delete();
    mq[1].delete();
    mcred[0] = CREDITS;
    mcred[1] = CREDITS;
    mptr = 0;
    merr = 1'b0;
  endtask

  // One clock: drive inputs, check ready, advance model, check outputs.
  task automatic step(input bit v, input int vc, input logic [7:0] a,
                      input logic [7:0] d, input logic [1:0] g,
                      output bit acc);
    bit          exp_ready;
    int          w;
    int          c;
    logic [1:0]  exp_tgt;
    logic [15:0] exp_pkt;
    client_valid = v;
    client_vc    = vc[0];
    client_addr  = a;
    client_data  = d;
    gnt          = g;
    #1;
    exp_ready = (mq[vc].size() < DEPTH);
    vectors++;
    if (client_ready !== exp_ready) begin
      miscompares++;
      $display("FAIL ready vc%0d: got %b want %b", vc, client_ready, exp_ready);
    end
    acc = v && exp_ready;
    w = -1;
    for (int i = 0; i < 2; i++) begin
      c = (mptr + i) % 2;
      if (w < 0 && mq[c].size() > 0 && mcred[c] > 0)
        w = c;
    end
    exp_tgt = 2'b00;
    exp_pkt = '0;
    if (w >= 0) begin
      exp_tgt = 2'b01 << w;
      exp_pkt = mq[w].pop_front();
      mcred[w]--;
      mptr = (w + 1) % 2;
    end
    for (int k = 0; k < 2; k++) begin
      if (g[k]) begin
        if (mcred[k] >= CREDITS) merr = 1'b1;
        else mcred[k]++;
      end
    end
    if (acc) mq[vc].push_back({a, d});
    @(posedge clk);
    #1;
    vectors++;
    if (credit_vc_target !== exp_tgt) begin
      miscompares++;
      $display("FAIL target: got %b want %b", credit_vc_target, exp_tgt);
    end
    vectors++;
    if (credit_err !== merr) begin
      miscompares++;
      $display("FAIL err: got %b want %b", credit_err, merr);
    end
    if (w >= 0) begin
      vectors++;
      if (credit_packet !== exp_pkt) begin
        miscompares++;
        $display("FAIL packet: got %h want %h", credit_packet, exp_pkt);
      end
    end
    client_valid = 1'b0;
    gnt = '0;
  endtask

  task automatic idle(input int n);
    bit acc;
    repeat (n) step(1'b0, 0, 8'h0, 8'h0, 2'b00, acc);
  endtask

  task automatic send_pkt(input int vc, input logic [7:0] d,
                          input logic [1:0] g);
    bit          acc;
    logic [7:0]  a;
    logic [1:0]  gg;
    a  = 8'($urandom);
    gg = g;
    for (int t = 0; t < 16; t++) begin
      step(1'b1, vc, a, d, gg, acc);
      gg = '0;
      if (acc) return;
    end
    vectors++;
    miscompares++;
    $display("FAIL accept_timeout vc%0d: got no accept want accept", vc);
  endtask

  task automatic restore();
    bit         acc;
    logic [1:0] g;
    for (int t = 0; t < 12; t++) begin
      g[0] = (mcred[0] < CREDITS);
      g[1] = (mcred[1] < CREDITS);
      if (g == 2'b00 && mq[0].size() == 0 && mq[1].size() == 0) return;
      step(1'b0, 0, 8'h0, 8'h0, g, acc);
    end
  endtask

  task automatic check_ready(input int vc, input bit want, input string nm);
    client_vc = vc[0];
    #1;
    vectors++;
    if (client_ready !== want) begin
      miscompares++;
      $display("FAIL %s: got %b want %b", nm, client_ready, want);
    end
  endtask

  task automatic check_cleared(input string nm);
    vectors++;
    if (credit_vc_target !== 2'b00 || credit_packet !== 16'h0 ||
        credit_err !== 1'b0) begin
      miscompares++;
      $display("FAIL %s: got tgt=%b pkt=%h err=%b want 0/0/0",
               nm, credit_vc_target, credit_packet, credit_err);
    end
  endtask

  task automatic test_reset();
    model_reset();
    rst_n = 1'b0;
    #12;
    check_cleared("reset_outputs");
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_ready(0, 1'b1, "reset_ready_vc0");
    check_ready(1, 1'b1, "reset_ready_vc1");
    idle(5);
  endtask

  task automatic test_single_vc();
    send_pkt(0, 8'h11, 2'b00);
    send_pkt(0, 8'h22, 2'b00);
    send_pkt(0, 8'h33, 2'b00);
    idle(3);
    begin
      bit acc;
      step(1'b0, 0, 8'h0, 8'h0, 2'b01, acc);
    end
    idle(3);
    restore();
  endtask

  task automatic test_round_robin();
    send_pkt(0, 8'hA0, 2'b00);
    send_pkt(1, 8'hB0, 2'b00);
    send_pkt(0, 8'hA1, 2'b00);
    send_pkt(1, 8'hB1, 2'b00);
    idle(2);
    send_pkt(0, 8'hC0, 2'b00);
    send_pkt(1, 8'hD0, 2'b00);
    send_pkt(0, 8'hC1, 2'b00);
    send_pkt(1, 8'hD1, 2'b00);
    begin
      bit acc;
      step(1'b0, 0, 8'h0, 8'h0, 2'b11, acc);
      step(1'b0, 0, 8'h0, 8'h0, 2'b11, acc);
    end
    idle(4);
    restore();
  endtask

  task automatic test_same_cycle();
    bit acc;
    send_pkt(1, 8'h51, 2'b00);
    idle(1);
    send_pkt(1, 8'h52, 2'b00);
    step(1'b1, 1, 8'h77, 8'h53, 2'b10, acc);
    idle(2);
    send_pkt(1, 8'h54, 2'b00);
    idle(2);
    restore();
  endtask

  task automatic test_overflow();
    bit acc;
    step(1'b0, 0, 8'h0, 8'h0, 2'b01, acc);
    idle(3);
    send_pkt(0, 8'h61, 2'b00);
    send_pkt(0, 8'h62, 2'b00);
    send_pkt(0, 8'h63, 2'b00);
    idle(3);
    restore();
  endtask

  task automatic test_ready_reset();
    send_pkt(1, 8'h71, 2'b00);
    send_pkt(1, 8'h72, 2'b00);
    send_pkt(1, 8'h73, 2'b00);
    send_pkt(1, 8'h74, 2'b00);
    idle(1);
    check_ready(1, 1'b0, "full_ready_vc1");
    check_ready(0, 1'b1, "free_ready_vc0");
    send_pkt(0, 8'h75, 2'b00);
    #2;
    rst_n = 1'b0;
    #1;
    check_cleared("async_reset_outputs");
    model_reset();
    @(negedge clk);
    rst_n = 1'b1;
    @(posedge clk);
    #1;
    check_ready(1, 1'b1, "post_reset_ready_vc1");
    idle(3);
    send_pkt(1, 8'h81, 2'b00);
    send_pkt(1, 8'h82, 2'b00);
    idle(3);
    restore();
  endtask

  task automatic test_random();
    bit          acc;
    bit          pend = 1'b0;
    int          vc = 0;
    logic [7:0]  a = '0;
    logic [7:0]  d = '0;
    logic [1:0]  g;
    bit          v;
    for (int n = 0; n < 400; n++) begin
      if (!pend && ($urandom % 3 != 0)) begin
        pend = 1'b1;
        vc   = int'($urandom % 2);
        a    = 8'($urandom);
        d    = 8'($urandom);
      end
      v = pend;
      g[0] = (mcred[0] < CREDITS) && ($urandom % 3 == 0);
      g[1] = (mcred[1] < CREDITS) && ($urandom % 3 == 0);
      step(v, vc, a, d, g, acc);
      if (acc) pend = 1'b0;
    end
    idle(4);
    restore();
  endtask

  initial begin
    test_reset();
    test_single_vc();
    test_round_robin();
    test_same_cycle();
    test_overflow();
    test_ready_reset();
    test_random();
    $display("== %0d vectors applied, %0d miscompares ==",
             vectors, miscompares);
    $finish;
  end

endmodule
